ttt_game_ctrl: RTL and testbench
================================

TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock (25 MHz); all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port key_valid, input, 1 bit: single-cycle strobe marking key_code valid.
REQ-004 SHALL have port key_code, input, 4 bits: key value. 1..9 are cells, 10 is '*', 11 is '#'; 0 and 12..15 are ignored.
REQ-005 SHALL have port start, input, 1 bit: single-cycle new-game request.
REQ-006 SHALL have port board, output, 18 bits: cell k (1..9) occupies bits [19-2k:18-2k]. 00 is empty, 01 is X, 10 is O.
REQ-007 SHALL have port turn_o, output, 1 bit: 1 means O to move, 0 means X to move.
REQ-008 SHALL have port result, output, 2 bits: 00 in progress, 01 X win, 10 O win, 11 draw.
REQ-009 SHALL have port game_state, output, 2 bits: 00 IDLE, 01 PLAY, 10 CHECK, 11 DONE.
REQ-010 SHALL have port is_right, output, 1 bit: display-shift flag.
REQ-011 SHALL have port move_cnt, output, 4 bits: moves placed, 0..9.
REQ-012 SHALL have port illegal, output, 1 bit: one-cycle pulse when a move is rejected.

Function
REQ-013 SHALL leave IDLE only on start, and SHALL go to PLAY with board=0, turn_o=0, result=00 and move_cnt=0.
REQ-014 SHALL, in PLAY, accept key_valid with key_code 1..9 and target cell 00:
- write 01 (turn_o=0) or 10 (turn_o=1) into that cell on the next edge;
- increment move_cnt;
- enter CHECK.
REQ-015 SHALL, in PLAY, reject key_valid with key_code 1..9 and target cell not 00: pulse illegal for exactly one cycle; board, turn_o, move_cnt and state unchanged.
REQ-016 SHALL, in CHECK (exactly one cycle), evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the player who just moved only, and take the first matching outcome:
- a line is complete: set result to 01 or 10 and go to DONE;
- else move_cnt==9: set result to 11 and go to DONE;
- else: toggle turn_o and return to PLAY.
REQ-017 SHALL test a win before a draw, so that a winning ninth move yields 01 or 10, never 11.
REQ-018 SHALL update board one cycle after an accepted key edge, and SHALL update result, turn_o and game_state two cycles after it.
REQ-019 SHALL ignore cell keys (1..9) in IDLE, CHECK and DONE, with no illegal pulse.
REQ-020 SHALL set is_right=0 on key 10 and is_right=1 on key 11, in every state, including CHECK.
REQ-021 SHALL, on start in PLAY, CHECK or DONE, restart exactly as in REQ-013.
REQ-022 SHALL give start priority over key_valid when both occur in the same cycle; the key is dropped and no illegal pulse is issued.
REQ-023 SHALL hold board, result and turn_o stable in DONE until start or rst.
REQ-024 SHALL treat board encoding 11 as occupied; the block never writes 11.
REQ-025 SHALL saturate move_cnt at 9 and never wrap.

Reset
REQ-026 SHALL, on rst, immediately set: board=0, turn_o=0, result=00, game_state=IDLE, is_right=0, move_cnt=0, illegal=0.
REQ-027 SHALL, on rst asserted mid-game (including during CHECK), abandon the game with no partial write surviving.
REQ-028 SHALL, after rst deasserts, require start before accepting any move.

Structure
REQ-029 SHALL take the following constants from shared package ttt_pkg: cell encodings (EMPTY, X, O), result codes, game_state encodings and key codes (KEY_STAR=10, KEY_HASH=11).
REQ-030 SHALL implement line evaluation in one combinational sub-module, ttt_win_check, with inputs board[17:0] and player, and output win.
REQ-031 SHALL use a single FSM register plus board, turn, count and flag registers; no other clock domains or derived clocks.

Verification
REQ-032 Reset: assert rst mid-PLAY -> all outputs at REQ-026 values in the same cycle; key 5 without start -> board stays 0.
REQ-033 X row win: start, then keys 1,4,2,5,3 ->
- board=18'b01_01_01_10_10_00_00_00_00 (binary);
- result=01 and game_state=DONE two cycles after the fifth key.
REQ-034 Illegal move: start, keys 1,1 -> second key gives illegal high for one cycle, board[17:16]=01, turn_o stays 1, move_cnt=1.
REQ-035 Draw: start, keys 1,2,3,5,4,6,8,7,9 -> result=11 and move_cnt=9; a further key 5 changes nothing.
REQ-036 Display and priority:
- keys 11 then 10 in DONE -> is_right goes 1 then 0;
- start together with key 7 in PLAY -> board=0 and turn_o=0 on the next cycle.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared constants and helpers for the tic-tac-toe controller: cell, result,
// state and key encodings plus board cell access.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_XWIN = 2'b01;
  localparam logic [1:0] RES_OWIN = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;
  localparam logic [3:0] MAX_MOVES = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_CHECK = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Cell k (1..9) lives at bits [19-2k:18-2k], so cell 1 is the top pair.
  function automatic logic [1:0] getCell(input logic [17:0] b, input int k);
    return b[(19 - 2*k) -: 2];
  endfunction

  function automatic logic [1:0] playerCode(input logic p);
    return p ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational three-in-a-row detector for a single player on the 3x3 board.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic        player,
  output logic        win
);

  logic [1:0] w_code;
  logic [9:1] w_mine;

  always_comb begin
    w_code = playerCode(player);
    w_mine = '0;
    for (int k = 1; k <= 9; k++) begin
      w_mine[k] = (getCell(board, k) == w_code);
    end
  end

  // Rows, columns, then the two diagonals.
  assign win = (w_mine[1] & w_mine[2] & w_mine[3]) |
               (w_mine[4] & w_mine[5] & w_mine[6]) |
               (w_mine[7] & w_mine[8] & w_mine[9]) |
               (w_mine[1] & w_mine[4] & w_mine[7]) |
               (w_mine[2] & w_mine[5] & w_mine[8]) |
               (w_mine[3] & w_mine[6] & w_mine[9]) |
               (w_mine[1] & w_mine[5] & w_mine[9]) |
               (w_mine[3] & w_mine[5] & w_mine[7]);

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: takes keypad moves, maintains the board and
// decides win/draw one cycle after each accepted move.
module ttt_game_ctrl
  import ttt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        start,
  output logic [17:0] board,
  output logic        turn_o,
  output logic [1:0]  result,
  output logic [1:0]  game_state,
  output logic        is_right,
  output logic [3:0]  move_cnt,
  output logic        illegal
);

  state_t      r_state;
  logic [17:0] r_board;
  logic        r_turn;
  logic [1:0]  r_result;
  logic [3:0]  r_cnt;
  logic        r_isRight;
  logic        r_illegal;

  state_t      w_stateNext;
  logic [17:0] w_boardNext;
  logic        w_turnNext;
  logic [1:0]  w_resultNext;
  logic [3:0]  w_cntNext;
  logic        w_isRightNext;
  logic        w_illegalNext;

  logic        w_isCell;
  logic [1:0]  w_target;
  logic [17:0] w_placed;
  logic        w_win;

  ttt_win_check u_winCheck (
    .board  (r_board),
    .player (r_turn),
    .win    (w_win)
  );

  // Occupancy of the addressed cell and the board with the mover's mark added;
  // encoding 11 counts as occupied because only 00 is accepted.
  always_comb begin
    w_isCell = (key_code >= 4'd1) && (key_code <= 4'd9);
    w_target = CELL_EMPTY;
    w_placed = r_board;
    for (int k = 1; k <= 9; k++) begin
      if (key_code == 4'(k)) begin
        w_target                 = getCell(r_board, k);
        w_placed[(19-2*k) -: 2]  = playerCode(r_turn);
      end
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_boardNext   = r_board;
    w_turnNext    = r_turn;
    w_resultNext  = r_result;
    w_cntNext     = r_cnt;
    w_isRightNext = r_isRight;
    w_illegalNext = 1'b0;

    if (start) begin
      w_stateNext  = ST_PLAY;
      w_boardNext  = '0;
      w_turnNext   = 1'b0;
      w_resultNext = RES_NONE;
      w_cntNext    = '0;
    end else begin
      if (key_valid && key_code == KEY_STAR) w_isRightNext = 1'b0;
      if (key_valid && key_code == KEY_HASH) w_isRightNext = 1'b1;

      unique case (r_state)
        ST_PLAY: begin
          if (key_valid && w_isCell) begin
            if (w_target == CELL_EMPTY) begin
              w_boardNext = w_placed;
              w_cntNext   = (r_cnt == MAX_MOVES) ? MAX_MOVES : r_cnt + 4'd1;
              w_stateNext = ST_CHECK;
            end else begin
              w_illegalNext = 1'b1;
            end
          end
        end
        // Win takes precedence over draw so a winning ninth move is a win.
        ST_CHECK: begin
          if (w_win) begin
            w_resultNext = r_turn ? RES_OWIN : RES_XWIN;
            w_stateNext  = ST_DONE;
          end else if (r_cnt == MAX_MOVES) begin
            w_resultNext = RES_DRAW;
            w_stateNext  = ST_DONE;
          end else begin
            w_turnNext  = ~r_turn;
            w_stateNext = ST_PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_board   <= '0;
      r_turn    <= 1'b0;
      r_result  <= RES_NONE;
      r_cnt     <= '0;
      r_isRight <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_board   <= w_boardNext;
      r_turn    <= w_turnNext;
      r_result  <= w_resultNext;
      r_cnt     <= w_cntNext;
      r_isRight <= w_isRightNext;
      r_illegal <= w_illegalNext;
    end
  end

  assign board      = r_board;
  assign turn_o     = r_turn;
  assign result     = r_result;
  assign game_state = r_state;
  assign is_right   = r_isRight;
  assign move_cnt   = r_cnt;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl: reset, wins, draw, illegal
// moves, display keys and start priority.
module tb_ttt_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        start;
  logic [17:0] board;
  logic        turn_o;
  logic [1:0]  result;
  logic [1:0]  game_state;
  logic        is_right;
  logic [3:0]  move_cnt;
  logic        illegal;

  int errors = 0;
  int checks = 0;
  int seq[$];

  ttt_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .start      (start),
    .board      (board),
    .turn_o     (turn_o),
    .result     (result),
    .game_state (game_state),
    .is_right   (is_right),
    .move_cnt   (move_cnt),
    .illegal    (illegal)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One-cycle key strobe; returns just after the edge that sampled it.
  task automatic applyStimulus(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic startGame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Each move gets its key cycle plus the CHECK cycle.
  task automatic playSeq();
    foreach (seq[i]) begin
      applyStimulus(4'(seq[i]));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; start = 1'b0;
    tick(); tick();
    checkOutput("rst_board",   18'(board),      18'd0);
    checkOutput("rst_state",   18'(game_state), 18'd0);
    checkOutput("rst_turn",    18'(turn_o),     18'd0);
    checkOutput("rst_result",  18'(result),     18'd0);
    checkOutput("rst_cnt",     18'(move_cnt),   18'd0);
    checkOutput("rst_isright", 18'(is_right),   18'd0);
    checkOutput("rst_illegal", 18'(illegal),    18'd0);
    rst = 1'b0;
    tick();

    applyStimulus(4'd5);
    tick();
    checkOutput("idle_key_board", 18'(board),      18'd0);
    checkOutput("idle_key_state", 18'(game_state), 18'd0);
    checkOutput("idle_key_ill",   18'(illegal),    18'd0);

    startGame();
    checkOutput("start_state", 18'(game_state), 18'd1);
    applyStimulus(4'd1);
    checkOutput("first_board", board,            18'b01_00_00_00_00_00_00_00_00);
    checkOutput("first_state", 18'(game_state), 18'd2);
    checkOutput("first_cnt",   18'(move_cnt),   18'd1);
    tick();
    checkOutput("first_turn",  18'(turn_o),     18'd1);
    checkOutput("first_play",  18'(game_state), 18'd1);

    #5 rst = 1'b1;
    #1;
    checkOutput("async_board", board,            18'd0);
    checkOutput("async_state", 18'(game_state), 18'd0);
    checkOutput("async_turn",  18'(turn_o),     18'd0);
    checkOutput("async_cnt",   18'(move_cnt),   18'd0);
    rst = 1'b0;
    tick();

    startGame();
    applyStimulus(4'd5);
    checkOutput("chk_state", 18'(game_state), 18'd2);
    #3 rst = 1'b1;
    #1;
    checkOutput("chk_rst_board", board,            18'd0);
    checkOutput("chk_rst_state", 18'(game_state), 18'd0);
    rst = 1'b0;
    tick();
    checkOutput("chk_rst_hold", board,            18'd0);
    checkOutput("chk_rst_idle", 18'(game_state), 18'd0);

    startGame();
    seq = '{1, 4, 2, 5};
    playSeq();
    applyStimulus(4'd3);
    checkOutput("xrow_board",    board,            18'b01_01_01_10_10_00_00_00_00);
    checkOutput("xrow_pending",  18'(result),     18'd0);
    tick();
    checkOutput("xrow_result",   18'(result),     18'd1);
    checkOutput("xrow_state",    18'(game_state), 18'd3);
    applyStimulus(4'd11);
    checkOutput("disp_hash",     18'(is_right),   18'd1);
    applyStimulus(4'd10);
    checkOutput("disp_star",     18'(is_right),   18'd0);
    applyStimulus(4'd6);
    checkOutput("done_board",    board,            18'b01_01_01_10_10_00_00_00_00);
    checkOutput("done_ill",      18'(illegal),    18'd0);
    checkOutput("done_result",   18'(result),     18'd1);

    startGame();
    checkOutput("restart_board", board,            18'd0);
    checkOutput("restart_res",   18'(result),     18'd0);
    applyStimulus(4'd1);
    tick();
    applyStimulus(4'd1);
    checkOutput("ill_pulse",  18'(illegal),    18'd1);
    checkOutput("ill_board",  18'(board[17:16]), 18'd1);
    checkOutput("ill_turn",   18'(turn_o),     18'd1);
    checkOutput("ill_cnt",    18'(move_cnt),   18'd1);
    checkOutput("ill_state",  18'(game_state), 18'd1);
    tick();
    checkOutput("ill_drop",   18'(illegal),    18'd0);

    start = 1'b1; key_valid = 1'b1; key_code = 4'd7;
    tick();
    start = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    checkOutput("prio_board", board,            18'd0);
    checkOutput("prio_turn",  18'(turn_o),     18'd0);
    checkOutput("prio_ill",   18'(illegal),    18'd0);
    checkOutput("prio_state", 18'(game_state), 18'd1);

    seq = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    playSeq();
    checkOutput("draw_result", 18'(result),   18'd3);
    checkOutput("draw_cnt",    18'(move_cnt), 18'd9);
    checkOutput("draw_board",  board,          18'b01_10_01_01_10_10_10_01_01);
    applyStimulus(4'd5);
    checkOutput("draw_ill",    18'(illegal),  18'd0);
    tick();
    checkOutput("draw_hold",   board,          18'b01_10_01_01_10_10_10_01_01);
    checkOutput("draw_cnt2",   18'(move_cnt), 18'd9);

    startGame();
    seq = '{1, 3, 2, 5, 4, 7};
    playSeq();
    checkOutput("owin_result", 18'(result),   18'd2);
    checkOutput("owin_cnt",    18'(move_cnt), 18'd6);
    checkOutput("owin_turn",   18'(turn_o),   18'd1);

    startGame();
    seq = '{1, 3, 5, 4, 2, 7, 6, 8, 9};
    playSeq();
    checkOutput("win9_result", 18'(result),     18'd1);
    checkOutput("win9_cnt",    18'(move_cnt),   18'd9);
    checkOutput("win9_state",  18'(game_state), 18'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
